// File: rtl/if_id_buffer.sv
// IF/ID boundary: two-entry {PC, instruction} buffer; a pair pushed into an empty buffer is on Id* right after that edge.
// Backpressure: FetchReady drops only at count 2 and depends solely on registered count; Flush empties the buffer in one cycle.
module if_id_buffer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        ReSet,
    input  logic        FetchValid,
    input  logic [31:0] FetchPC,
    input  logic [31:0] FetchInstr,
    output logic        FetchReady,
    input  logic        Flush,
    output logic        IdValid,
    output logic [31:0] IdPC,
    output logic [31:0] IdPC4,
    output logic [31:0] IdInstr,
    input  logic        IdReady,
    output logic [1:0]  Occupancy
);

    logic [31:0] entryPC    [2];
    logic [31:0] entryInstr [2];
    logic        rdPtr;
    logic        wrPtr;
    logic [1:0]  count;
    logic [31:0] heldPC;
    logic        push;
    logic        pop;

    assign FetchReady = (count != 2'd2);
    assign IdValid    = (count != 2'd0);
    assign push       = FetchValid & FetchReady & ~Flush;
    assign pop        = IdValid & IdReady & ~Flush;

    // Entry payloads need no reset: they are only observed while counted valid.
    always_ff @(posedge Clk) begin
        if (push) begin
            entryPC[wrPtr]    <= FetchPC;
            entryInstr[wrPtr] <= FetchInstr;
        end
    end

    always_ff @(posedge Clk or posedge ReSet) begin
        if (ReSet) begin
            rdPtr  <= 1'b0;
            wrPtr  <= 1'b0;
            count  <= 2'd0;
            heldPC <= RESET_PC;
        end else if (Flush) begin
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                wrPtr <= ~wrPtr;
            end
            if (pop) begin
                rdPtr  <= ~rdPtr;
                heldPC <= entryPC[rdPtr];
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // With the buffer empty, decode keeps seeing the last consumed PC and a bubble.
    always_comb begin
        IdPC    = heldPC;
        IdInstr = NOP_INSTR;
        if (IdValid) begin
            IdPC    = entryPC[rdPtr];
            IdInstr = entryInstr[rdPtr];
        end
    end

    assign IdPC4     = IdPC + 32'd4;
    assign Occupancy = count;

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboarded bench for if_id_buffer: a queue model predicts every output each cycle.
module tb_if_id_buffer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        ReSet;
    logic        FetchValid;
    logic [31:0] FetchPC;
    logic [31:0] FetchInstr;
    logic        FetchReady;
    logic        Flush;
    logic        IdValid;
    logic [31:0] IdPC;
    logic [31:0] IdPC4;
    logic [31:0] IdInstr;
    logic        IdReady;
    logic [1:0]  Occupancy;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } pair_t;

    pair_t       sbQ[$];
    logic [31:0] heldPC;
    int          checks = 0;
    int          errors = 0;

    if_id_buffer #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .Clk(Clk), .ReSet(ReSet),
        .FetchValid(FetchValid), .FetchPC(FetchPC), .FetchInstr(FetchInstr), .FetchReady(FetchReady),
        .Flush(Flush),
        .IdValid(IdValid), .IdPC(IdPC), .IdPC4(IdPC4), .IdInstr(IdInstr), .IdReady(IdReady),
        .Occupancy(Occupancy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkOutputs(input string tag);
        logic [31:0] expPC;
        logic [31:0] expInstr;
        expPC    = (sbQ.size() != 0) ? sbQ[0].pc : heldPC;
        expInstr = (sbQ.size() != 0) ? sbQ[0].instr : NOP;
        chk({tag, ".FetchReady"}, 32'(FetchReady), 32'(sbQ.size() != 2));
        chk({tag, ".IdValid"},    32'(IdValid),    32'(sbQ.size() != 0));
        chk({tag, ".Occupancy"},  32'(Occupancy),  32'(sbQ.size()));
        chk({tag, ".IdPC"},       IdPC,            expPC);
        chk({tag, ".IdPC4"},      IdPC4,           expPC + 32'd4);
        chk({tag, ".IdInstr"},    IdInstr,         expInstr);
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic rdy, input logic fl);
        FetchValid = fv;
        FetchPC    = pc;
        FetchInstr = instrOf(pc);
        IdReady    = rdy;
        Flush      = fl;
    endtask

    // Check outputs mid-cycle, then advance the model by the edge using the driven inputs.
    task automatic step(input string tag);
        bit    doPush;
        bit    doPop;
        pair_t p;
        @(negedge Clk);
        checkOutputs(tag);
        doPush = FetchValid && (sbQ.size() != 2) && !Flush;
        doPop  = (sbQ.size() != 0) && IdReady && !Flush;
        @(posedge Clk);
        if (Flush) begin
            sbQ.delete();
        end else begin
            if (doPop) begin
                heldPC = sbQ[0].pc;
                void'(sbQ.pop_front());
            end
            if (doPush) begin
                p.pc    = FetchPC;
                p.instr = FetchInstr;
                sbQ.push_back(p);
            end
        end
        #1;
    endtask

    initial begin
        ReSet  = 1'b1;
        heldPC = RST_PC;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge Clk);
        #1 ReSet = 1'b0;

        // reset state
        step("rst");

        // streaming with decode always ready
        drive(1'b1, 32'h0000_3000, 1'b1, 1'b0); step("s2a");
        drive(1'b1, 32'h0000_3004, 1'b1, 1'b0); step("s2b");
        drive(1'b1, 32'h0000_3008, 1'b1, 1'b0); step("s2c");
        drive(1'b0, 32'h0, 1'b1, 1'b0);         step("s2d");
        step("s2e");

        // stall: fill to 2, third pair held off, then drain in order
        drive(1'b1, 32'h0000_3000, 1'b0, 1'b0); step("s3a");
        drive(1'b1, 32'h0000_3004, 1'b0, 1'b0); step("s3b");
        drive(1'b1, 32'h0000_300C, 1'b0, 1'b0); step("s3c");
        step("s3d");
        drive(1'b1, 32'h0000_300C, 1'b1, 1'b0); step("s3e");
        step("s3f");
        drive(1'b0, 32'h0, 1'b1, 1'b0);         step("s3g");
        step("s3h");

        // flush with concurrent push and pop
        drive(1'b1, 32'h0000_3020, 1'b0, 1'b0); step("s4a");
        drive(1'b1, 32'h0000_3024, 1'b0, 1'b0); step("s4b");
        drive(1'b1, 32'h0000_3010, 1'b1, 1'b1); step("s4c");
        drive(1'b1, 32'h0000_4000, 1'b0, 1'b0); step("s4d");
        drive(1'b0, 32'h0, 1'b0, 1'b0);         step("s4e");
        drive(1'b0, 32'h0, 1'b1, 1'b0);         step("s4f");
        step("s4g");

        // PC+4 wraps at the top of the address space, held after pop too
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0); step("s5a");
        drive(1'b0, 32'h0, 1'b0, 1'b0);         step("s5b");
        chk("s5.IdPC4wrap", IdPC4, 32'h0000_0000);
        drive(1'b0, 32'h0, 1'b1, 1'b0);         step("s5c");
        step("s5d");

        // asynchronous reset while full
        drive(1'b1, 32'h0000_5000, 1'b0, 1'b0); step("s6a");
        drive(1'b1, 32'h0000_5004, 1'b0, 1'b0); step("s6b");
        drive(1'b0, 32'h0, 1'b0, 1'b0);         step("s6c");
        #2 ReSet = 1'b1;
        #1;
        sbQ.delete();
        heldPC = RST_PC;
        checkOutputs("s6.arst");
        @(posedge Clk);
        #1 ReSet = 1'b0;
        step("s6d");
        drive(1'b1, 32'h0000_6000, 1'b1, 1'b0); step("s6e");
        drive(1'b0, 32'h0, 1'b1, 1'b0);         step("s6f");
        step("s6g");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Two-entry instruction buffer that forms the IF/ID boundary of the pipelined processor. It sits directly downstream of the PC unit and instruction memory. Each cycle it accepts a fetched {PC, instruction} pair and presents it to the decode stage through a valid/ready handshake. It absorbs decode stalls without losing an in-flight fetch, and it is flushed when a branch redirects the PC.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value shown on `IdPC` while the buffer is empty after reset; matches the PC unit reset vector.
- `NOP_INSTR`, default 32'h0000_0000: instruction word shown on `IdInstr` when the buffer is empty.

Ports (name, direction, width, meaning):
- `Clk`  in  1  system clock; all state changes on its rising edge.
- `ReSet`  in  1  asynchronous, active-high reset.
- `FetchValid`  in  1  fetch stage presents a valid pair this cycle.
- `FetchPC`  in  32  PC of the fetched instruction.
- `FetchInstr`  in  32  instruction word from instruction memory.
- `FetchReady`  out  1  buffer can accept a pair this cycle; the PC unit must hold its PC while this is 0.
- `Flush`  in  1  branch taken; discard all buffered and incoming pairs.
- `IdValid`  out  1  head entry is valid.
- `IdPC`  out  32  PC of the head entry.
- `IdPC4`  out  32  `IdPC` + 4, modulo 2^32.
- `IdInstr`  out  32  instruction of the head entry.
- `IdReady`  in  1  decode consumes the head entry this cycle.
- `Occupancy`  out  2  number of valid entries (0..2).

## Operation
- Storage: 2 entries of {PC[31:0], Instr[31:0]}, circular, with a 1-bit read pointer, a 1-bit write pointer and a 2-bit count.
- Push condition: `FetchValid & FetchReady & ~Flush`. Writes the pair at the write pointer and advances it (wraps 1→0).
- Pop condition: `IdValid & IdReady & ~Flush`. Advances the read pointer (wraps 1→0).
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged.
  - Neither: unchanged.
- `FetchReady` = (count != 2). It is combinational from registered count only and never depends on `IdReady`.
- `IdValid` = (count != 0).
- When `IdValid` is 1, `IdPC` and `IdInstr` come from the entry at the read pointer.
- When `IdValid` is 0, `IdPC` holds the PC of the last entry popped (`RESET_PC` if none since reset) and `IdInstr` = `NOP_INSTR`.
- `IdPC4` is always `IdPC` + 32'd4, and the carry out is dropped, so 32'hFFFF_FFFC gives 0.
- Flush:
  - The next count is 0 and both pointers reset to 0.
  - A push or pop in the same cycle is ignored.
  - The held `IdPC` is unchanged.
- Reset (async, any time, including mid-transfer): count = 0, pointers = 0, held PC = `RESET_PC`. Entry contents are don't-care.
- Overflow and underflow are impossible by construction: a push at count 2 is blocked by `FetchReady`, and a pop at count 0 is blocked by `IdValid`.

## Timing
- Reset values of outputs:
  - `FetchReady` = 1
  - `IdValid` = 0
  - `IdPC` = `RESET_PC`
  - `IdPC4` = `RESET_PC` + 4
  - `IdInstr` = `NOP_INSTR`
  - `Occupancy` = 0
- Latency:
  - A pair pushed at edge k is on the `Id*` outputs right after edge k when the buffer was empty.
  - Otherwise it appears after the pops of the entries ahead of it.
- Throughput: one pair per cycle when `IdReady` is held at 1.
- Stall: with `IdReady` = 0, at most 2 pushes are accepted. `FetchReady` drops right after the edge that makes count 2.
- Flush asserted in cycle k: right after edge k, `IdValid` = 0 and `FetchReady` = 1. The first post-branch pair can be pushed at edge k+1.
- No output has a combinational path from `FetchValid`, `FetchPC`, `FetchInstr`, `IdReady` or `Flush`.

## Test plan
1. Reset released, `FetchValid` = 0 → `IdValid` = 0, `IdPC` = 0x3000, `IdPC4` = 0x3004, `IdInstr` = 0, `FetchReady` = 1.
2. Stream PCs 0x3000, 0x3004, 0x3008 with `IdReady` = 1 every cycle → `IdPC` follows one cycle behind each push, `Occupancy` stays 1, no pair is lost or duplicated.
3. Push 0x3000 and 0x3004 with `IdReady` = 0 → `Occupancy` = 2 and `FetchReady` = 0; a third pair held on the inputs is not accepted. Raise `IdReady` → 0x3000, then 0x3004, then the third pair, in order.
4. Buffer holds 2 entries; assert `Flush` together with `FetchValid` (PC 0x3010) and `IdReady` → next cycle `Occupancy` = 0, `IdValid` = 0, 0x3010 is dropped. Push 0x4000 → `IdPC` = 0x4000.
5. Push PC 0xFFFF_FFFC → `IdPC4` = 0x0000_0000.
6. Assert `ReSet` asynchronously between edges while `Occupancy` = 2 → outputs immediately return to the reset values of scenario 1.
